// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT butterfly scheduler: FSM encoding, butterfly
// operand select codes and the bank-assignment function.
package ntt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SEL_U0 = 2'd0;
    localparam logic [1:0] SEL_V0 = 2'd1;
    localparam logic [1:0] SEL_U1 = 2'd2;
    localparam logic [1:0] SEL_V1 = 2'd3;

    // Bank of a coefficient index: sum of its radix-4 digits, mod 4.
    function automatic logic [1:0] bank(input logic [31:0] idx);
        logic [1:0] acc;
        acc = '0;
        for (int j = 0; j < 16; j++) begin
            acc = acc + idx[2*j +: 2];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// Combinational index generator: maps (stage, cycle) to the four butterfly
// indices, their bank addresses, input-network selects and twiddle exponents.
module ntt_bank_map
    import ntt_sched_pkg::*;
#(
    parameter int LOGN   = 8,
    parameter int ADDR_W = 6,
    parameter int SW     = 3
) (
    input  logic [SW-1:0]     s,
    input  logic [ADDR_W-1:0] c,
    input  logic              inv,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic [1:0]        sel_a_0,
    output logic [1:0]        sel_a_1,
    output logic [1:0]        sel_a_2,
    output logic [1:0]        sel_a_3,
    output logic [LOGN-2:0]   tw_idx0,
    output logic [LOGN-2:0]   tw_idx1
);

    localparam logic [1:0] POS_SEL [4] = '{SEL_U0, SEL_V0, SEL_U1, SEL_V1};

    logic [LOGN-1:0]   bit_s;
    logic [LOGN-1:0]   bit_t;
    logic [LOGN-1:0]   low_mask;
    logic [LOGN-1:0]   i0;
    logic [LOGN-1:0]   idx [4];
    logic [ADDR_W-1:0] addr_k [4];
    logic [1:0]        sel_k [4];
    logic [LOGN-1:0]   tw_fwd0;
    logic [LOGN-1:0]   tw_fwd1;
    logic [LOGN-1:0]   tw_out0;
    logic [LOGN-1:0]   tw_out1;

    always_comb begin
        bit_s    = LOGN'(1) << s;
        bit_t    = LOGN'(1) << (s ^ SW'(1));
        // i0 is c with a zero radix-4 digit spliced in at digit s>>1
        low_mask = (LOGN'(1) << {s[SW-1:1], 1'b0}) - LOGN'(1);
        i0       = ((LOGN'(c) & ~low_mask) << 2) | (LOGN'(c) & low_mask);
        idx[0]   = i0;
        idx[1]   = i0 | bit_s;
        idx[2]   = i0 | bit_t;
        idx[3]   = i0 | bit_s | bit_t;
        for (int k = 0; k < 4; k++) begin
            addr_k[k] = '0;
            sel_k[k]  = '0;
        end
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (bank(32'(idx[p])) == 2'(k)) begin
                    addr_k[k] = idx[p][LOGN-1:2];
                    sel_k[k]  = POS_SEL[p];
                end
            end
        end
        tw_fwd0 = (i0 & (bit_s - LOGN'(1))) << (SW'(LOGN - 1) - s);
        tw_fwd1 = (idx[2] & (bit_s - LOGN'(1))) << (SW'(LOGN - 1) - s);
        tw_out0 = inv ? (LOGN'(0) - tw_fwd0) : tw_fwd0;
        tw_out1 = inv ? (LOGN'(0) - tw_fwd1) : tw_fwd1;
    end

    assign rd_addr0 = addr_k[0];
    assign rd_addr1 = addr_k[1];
    assign rd_addr2 = addr_k[2];
    assign rd_addr3 = addr_k[3];
    assign sel_a_0  = sel_k[0];
    assign sel_a_1  = sel_k[1];
    assign sel_a_2  = sel_k[2];
    assign sel_a_3  = sel_k[3];
    assign tw_idx0  = tw_out0[LOGN-2:0];
    assign tw_idx1  = tw_out1[LOGN-2:0];

endmodule

// File: rtl/ntt_bf_sched.sv
// Stage/address sequencer for the 2-BFU radix-2 NTT core: FSM, counters and
// the read-to-write delay line. Define NTT_SCHED_INV_EN for descending-stage mode.
module ntt_bf_sched
    import ntt_sched_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOGN   = 8,
    parameter int ADDR_W = 6,
    parameter int BF_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef NTT_SCHED_INV_EN
    input  logic                    inv,
`endif
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr0,
    output logic [ADDR_W-1:0]       rd_addr1,
    output logic [ADDR_W-1:0]       rd_addr2,
    output logic [ADDR_W-1:0]       rd_addr3,
    output logic [1:0]              sel_a_0,
    output logic [1:0]              sel_a_1,
    output logic [1:0]              sel_a_2,
    output logic [1:0]              sel_a_3,
    output logic [LOGN-2:0]         tw_idx0,
    output logic [LOGN-2:0]         tw_idx1,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr0,
    output logic [ADDR_W-1:0]       wr_addr1,
    output logic [ADDR_W-1:0]       wr_addr2,
    output logic [ADDR_W-1:0]       wr_addr3,
    output logic [1:0]              sel_b_0,
    output logic [1:0]              sel_b_1,
    output logic [1:0]              sel_b_2,
    output logic [1:0]              sel_b_3,
    output logic [$clog2(LOGN)-1:0] stage,
    output logic                    busy,
    output logic                    done
);

    localparam int SW  = $clog2(LOGN);
    localparam int LAT = 1 + BF_LAT;
    localparam int FW  = (LAT > 2) ? $clog2(LAT) : 1;
    localparam int PW  = 1 + 4 * ADDR_W + 8;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N / 4 - 1);
    localparam logic [FW-1:0]     F_LAST = FW'(LAT - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [FW-1:0]     f_q, f_d;
    logic              inv_q, inv_d;
    logic              inv_in;
    logic              last_stage;
    logic [PW-1:0]     pipe_q [LAT];
    logic [PW-1:0]     pipe_d [LAT];

    logic [ADDR_W-1:0] m_addr0, m_addr1, m_addr2, m_addr3;
    logic [1:0]        m_sel0, m_sel1, m_sel2, m_sel3;
    logic [LOGN-2:0]   m_tw0, m_tw1;

`ifdef NTT_SCHED_INV_EN
    assign inv_in = inv;
`else
    assign inv_in = 1'b0;
`endif

    ntt_bank_map #(.LOGN(LOGN), .ADDR_W(ADDR_W), .SW(SW)) u_map (
        .s        (s_q),
        .c        (c_q),
        .inv      (inv_q),
        .rd_addr0 (m_addr0),
        .rd_addr1 (m_addr1),
        .rd_addr2 (m_addr2),
        .rd_addr3 (m_addr3),
        .sel_a_0  (m_sel0),
        .sel_a_1  (m_sel1),
        .sel_a_2  (m_sel2),
        .sel_a_3  (m_sel3),
        .tw_idx0  (m_tw0),
        .tw_idx1  (m_tw1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            f_q     <= '0;
            inv_q   <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            f_q     <= f_d;
            inv_q   <= inv_d;
            pipe_q  <= pipe_d;
        end
    end

    // Final stage is s==LOGN-1 ascending, s==0 when running inverse order.
    assign last_stage = inv_q ? (s_q == '0) : (s_q == SW'(LOGN - 1));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        f_d     = f_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    inv_d   = inv_in;
                    s_d     = inv_in ? SW'(LOGN - 1) : '0;
                    c_d     = '0;
                end
            end
            ST_RUN: begin
                if (c_q == C_LAST) begin
                    state_d = ST_FLUSH;
                    c_d     = '0;
                    f_d     = '0;
                end else begin
                    c_d = c_q + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (f_q == F_LAST) begin
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = inv_q ? (s_q - SW'(1)) : (s_q + SW'(1));
                    end
                end else begin
                    f_d = f_q + FW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                inv_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state_q == ST_RUN);
        busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done     = (state_q == ST_DONE);
        stage    = s_q;
        rd_addr0 = rd_en ? m_addr0 : '0;
        rd_addr1 = rd_en ? m_addr1 : '0;
        rd_addr2 = rd_en ? m_addr2 : '0;
        rd_addr3 = rd_en ? m_addr3 : '0;
        sel_a_0  = rd_en ? m_sel0 : '0;
        sel_a_1  = rd_en ? m_sel1 : '0;
        sel_a_2  = rd_en ? m_sel2 : '0;
        sel_a_3  = rd_en ? m_sel3 : '0;
        tw_idx0  = rd_en ? m_tw0 : '0;
        tw_idx1  = rd_en ? m_tw1 : '0;
        {wr_en, wr_addr3, wr_addr2, wr_addr1, wr_addr0,
         sel_b_3, sel_b_2, sel_b_1, sel_b_0} = pipe_q[LAT-1];
    end

    // Write controls replay the read controls LAT cycles later.
    always_comb begin
        pipe_d[0] = {rd_en, rd_addr3, rd_addr2, rd_addr1, rd_addr0,
                     sel_a_3, sel_a_2, sel_a_1, sel_a_0};
        for (int k = 1; k < LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Bench for ntt_bf_sched: model-filled expected queues checked by a monitor,
// plus hand-computed vectors, mid-run start/reset, and inverse mode when enabled.
`timescale 1ns/1ps
module tb_ntt_bf_sched;

    localparam int N      = 256;
    localparam int LOGN   = 8;
    localparam int ADDR_W = 6;
    localparam int LAT    = 4;
    localparam int SPAN   = N / 4 + LAT;
    localparam int RW     = 3 + 4 * ADDR_W + 8 + 2 * (LOGN - 1) + 16;
    localparam int WW     = 4 * ADDR_W + 8 + 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
`ifdef NTT_SCHED_INV_EN
    logic inv = 1'b0;
`endif
    logic              rd_en, wr_en, busy, done;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [ADDR_W-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
    logic [1:0]        sel_a_0, sel_a_1, sel_a_2, sel_a_3;
    logic [1:0]        sel_b_0, sel_b_1, sel_b_2, sel_b_3;
    logic [LOGN-2:0]   tw_idx0, tw_idx1;
    logic [2:0]        stage;

    ntt_bf_sched dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef NTT_SCHED_INV_EN
        .inv(inv),
`endif
        .rd_en(rd_en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
        .tw_idx0(tw_idx0), .tw_idx1(tw_idx1),
        .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3),
        .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
        .stage(stage), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [RW-1:0] exp_rd_q[$];
    logic [WW-1:0] exp_wr_q[$];
    logic [15:0]   exp_done_q[$];
    logic [15:0]   rel_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] rel);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an output event at cycle %0d, required none", name, rel);
    endtask

    function automatic logic [127:0] all_outputs();
        return {rd_en, wr_en, busy, done, stage,
                rd_addr3, rd_addr2, rd_addr1, rd_addr0,
                sel_a_3, sel_a_2, sel_a_1, sel_a_0, tw_idx0, tw_idx1,
                wr_addr3, wr_addr2, wr_addr1, wr_addr0,
                sel_b_3, sel_b_2, sel_b_1, sel_b_0};
    endfunction

    // Independent model of one full transform; keeps events before 'limit'.
    task automatic push_model(input bit inv_v, input int limit);
        for (int p = 0; p < LOGN; p++) begin
            for (int c = 0; c < N / 4; c++) begin
                int s, d, k, i0, t, bk, twa, twb, rc;
                int ix[4];
                logic [ADDR_W-1:0] ad[4];
                logic [1:0] sl[4];
                s  = inv_v ? (LOGN - 1 - p) : p;
                rc = p * SPAN + c;
                d  = s / 2;
                k  = 0;
                i0 = 0;
                for (int b = 0; b < LOGN; b++) begin
                    if (b / 2 != d) begin
                        i0 = i0 | (((c >> k) & 1) << b);
                        k++;
                    end
                end
                t = s ^ 1;
                ix[0] = i0;
                ix[1] = i0 | (1 << s);
                ix[2] = i0 | (1 << t);
                ix[3] = ix[1] | (1 << t);
                for (int q = 0; q < 4; q++) begin
                    bk = 0;
                    for (int j = 0; j < LOGN / 2; j++) bk += (ix[q] >> (2 * j)) & 3;
                    bk = bk % 4;
                    ad[bk] = ADDR_W'(ix[q] >> 2);
                    sl[bk] = 2'(q);
                end
                twa = (i0 % (1 << s)) << (LOGN - 1 - s);
                twb = (ix[2] % (1 << s)) << (LOGN - 1 - s);
                if (inv_v) begin
                    twa = (N - twa) % N;
                    twb = (N - twb) % N;
                end
                twa = twa % (N / 2);
                twb = twb % (N / 2);
                if (rc < limit)
                    exp_rd_q.push_back({3'(s), ad[3], ad[2], ad[1], ad[0],
                                        sl[3], sl[2], sl[1], sl[0], 7'(twa), 7'(twb), 16'(rc)});
                if (rc + LAT < limit)
                    exp_wr_q.push_back({ad[3], ad[2], ad[1], ad[0],
                                        sl[3], sl[2], sl[1], sl[0], 16'(rc + LAT)});
            end
        end
        if (LOGN * SPAN < limit) exp_done_q.push_back(16'(LOGN * SPAN));
    endtask

    // Monitor: pops an expectation whenever the DUT presents a read, write or done.
    always @(negedge clk) begin
        rel_m = 16'(cyc - base);
        if (busy) busy_cnt++;
        if (rd_en) begin
            if (exp_rd_q.size() == 0) unexpected("rd_extra", rel_m);
            else check("rd_txn", {stage, rd_addr3, rd_addr2, rd_addr1, rd_addr0,
                                  sel_a_3, sel_a_2, sel_a_1, sel_a_0, tw_idx0, tw_idx1, rel_m},
                       exp_rd_q.pop_front());
        end
        if (wr_en) begin
            if (exp_wr_q.size() == 0) unexpected("wr_extra", rel_m);
            else check("wr_txn", {wr_addr3, wr_addr2, wr_addr1, wr_addr0,
                                  sel_b_3, sel_b_2, sel_b_1, sel_b_0, rel_m},
                       exp_wr_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            check("done_busy_low", 128'(busy), 128'(0));
            if (exp_done_q.size() == 0) unexpected("done_extra", rel_m);
            else check("done_cycle", 128'(rel_m), 128'(exp_done_q.pop_front()));
        end
    end

    task automatic launch(input bit inv_v, input int limit);
        push_model(inv_v, limit);
        @(negedge clk);
        start = 1'b1;
`ifdef NTT_SCHED_INV_EN
        inv = inv_v;
`endif
        base = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) @(negedge clk);
    endtask

    task automatic full_run(input bit inv_v, input string tag);
        int b0, d0;
        b0 = busy_cnt;
        d0 = done_cnt;
        launch(inv_v, 1 << 30);
        check({tag, "_first_stage"}, 128'(stage), inv_v ? 128'(LOGN - 1) : 128'(0));
        wait_rel(LOGN * SPAN + 12);
        check({tag, "_busy_cycles"}, 128'(busy_cnt - b0), 128'(LOGN * SPAN));
        check({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'(1));
        check({tag, "_rd_left"}, 128'(exp_rd_q.size()), 128'(0));
        check({tag, "_wr_left"}, 128'(exp_wr_q.size()), 128'(0));
        check({tag, "_idle_quiet"}, all_outputs(), 128'(0));
    endtask

    initial begin
        int b0, d0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 128'(0));

        // Directed vectors on a full forward run, with a stray start at cycle 10.
        b0 = busy_cnt;
        d0 = done_cnt;
        launch(1'b0, 1 << 30);
        check("s0c0_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 128'(0));
        check("s0c0_sel", {sel_a_3, sel_a_2, sel_a_1, sel_a_0}, 128'(8'b11_10_01_00));
        check("s0c0_tw", {tw_idx0, tw_idx1}, 128'(0));
        wait_rel(1);
        check("s0c1_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 128'({6'd1, 6'd1, 6'd1, 6'd1}));
        check("s0c1_sel", {sel_a_3, sel_a_2, sel_a_1, sel_a_0}, 128'(8'b10_01_00_11));
        wait_rel(4);
        check("wr_lag_s0c0", {wr_en, wr_addr0, sel_b_0}, 128'({1'b1, 6'd0, 2'b00}));
        wait_rel(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rel(2 * SPAN);
        check("s2c0_stage", 128'(stage), 128'(2));
        check("s2c0_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 128'({6'd3, 6'd2, 6'd1, 6'd0}));
        check("s2c0_sel", {sel_a_3, sel_a_2, sel_a_1, sel_a_0}, 128'(8'b11_10_01_00));
        wait_rel(LOGN * SPAN + 12);
        check("run1_busy_cycles", 128'(busy_cnt - b0), 128'(LOGN * SPAN));
        check("run1_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("run1_rd_left", 128'(exp_rd_q.size()), 128'(0));
        check("run1_wr_left", 128'(exp_wr_q.size()), 128'(0));

        // Reset mid-run at cycle 100: in-flight writes must never appear.
        launch(1'b0, 100);
        wait_rel(99);
        rst = 1'b0;
        @(negedge clk);
        check("in_reset_outputs", all_outputs(), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", all_outputs(), 128'(0));
        repeat (8) @(negedge clk);
        check("post_reset_quiet", all_outputs(), 128'(0));
        check("abort_rd_left", 128'(exp_rd_q.size()), 128'(0));
        check("abort_wr_left", 128'(exp_wr_q.size()), 128'(0));

        full_run(1'b0, "rerun");
`ifdef NTT_SCHED_INV_EN
        full_run(1'b1, "inverse");
        full_run(1'b0, "forward_after_inv");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
